// File: rtl/sram_writer.sv
// rtl/sram_writer.sv - pixel stream to linear frame-buffer BRAM write cycles
// Optional SRAM_WRITER_FRAME_SYNC_EN adds frame_start input and frame_done output.
module sram_writer #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] scaled_data,
  input  logic              scaled_valid,
`ifdef SRAM_WRITER_FRAME_SYNC_EN
  input  logic              frame_start,
  output logic              frame_done,
`endif
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_data_q, bram_data_d;
  logic              bram_we_q, bram_we_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] ptr_cur;

  always_comb begin
    ptr_cur      = wr_ptr_q;
`ifdef SRAM_WRITER_FRAME_SYNC_EN
    // A frame start re-bases this cycle's pixel to address 0, ahead of any wrap.
    if (frame_start) ptr_cur = '0;
`endif
    wr_ptr_d     = ptr_cur;
    bram_addr_d  = bram_addr_q;
    bram_data_d  = bram_data_q;
    bram_we_d    = 1'b0;
    frame_done_d = 1'b0;
    if (scaled_valid) begin
      bram_we_d    = 1'b1;
      bram_data_d  = scaled_data;
      bram_addr_d  = ptr_cur;
      wr_ptr_d     = (ptr_cur == LAST_ADDR) ? '0 : ptr_cur + 1'b1;
      frame_done_d = (ptr_cur == LAST_ADDR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      bram_addr_q  <= '0;
      bram_data_q  <= '0;
      bram_we_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      bram_addr_q  <= bram_addr_d;
      bram_data_q  <= bram_data_d;
      bram_we_q    <= bram_we_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_data = bram_data_q;
  assign bram_we   = bram_we_q;
`ifdef SRAM_WRITER_FRAME_SYNC_EN
  assign frame_done = frame_done_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_sram_writer.sv
// tb/tb_sram_writer.sv - self-checking bench for sram_writer, default frame and an 8-pixel frame
// Frame-sync checks are compiled in when SRAM_WRITER_FRAME_SYNC_EN is defined.
module tb_sram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scaled_valid = 1'b0;
  logic [11:0] scaled_data = '0;
  logic        frame_start = 1'b0;

  logic [16:0] addr_a, addr_b;
  logic [11:0] data_a, data_b;
  logic        we_a, we_b;
  logic        fd_a, fd_b;

  int errors = 0;
  int checks = 0;

  int          fp [2];
  int          nxt [2];
  logic [16:0] ea [2];
  logic [11:0] ed [2];
  logic        ew [2];
  logic        efd [2];

  always #5 clk = ~clk;

  sram_writer #(.DATA_W(12), .ADDR_W(17), .FRAME_PIXELS(76800)) dut_a (
    .clk(clk), .rst(rst), .scaled_data(scaled_data), .scaled_valid(scaled_valid),
`ifdef SRAM_WRITER_FRAME_SYNC_EN
    .frame_start(frame_start), .frame_done(fd_a),
`endif
    .bram_addr(addr_a), .bram_data(data_a), .bram_we(we_a)
  );

  sram_writer #(.DATA_W(12), .ADDR_W(17), .FRAME_PIXELS(8)) dut_b (
    .clk(clk), .rst(rst), .scaled_data(scaled_data), .scaled_valid(scaled_valid),
`ifdef SRAM_WRITER_FRAME_SYNC_EN
    .frame_start(frame_start), .frame_done(fd_b),
`endif
    .bram_addr(addr_b), .bram_data(data_b), .bram_we(we_b)
  );

`ifndef SRAM_WRITER_FRAME_SYNC_EN
  assign fd_a = 1'b0;
  assign fd_b = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the k-th accepted pixel since reset/frame start lands at k mod frame size.
  task automatic model(input logic r, input logic v, input logic [11:0] d, input logic fs);
    for (int i = 0; i < 2; i++) begin
      efd[i] = 1'b0;
      if (r) begin
        nxt[i] = 0; ea[i] = '0; ed[i] = '0; ew[i] = 1'b0;
      end else begin
        if (fs) nxt[i] = 0;
        ew[i] = v;
        if (v) begin
          ea[i]  = 17'(nxt[i]);
          ed[i]  = d;
          efd[i] = (nxt[i] == fp[i] - 1);
          nxt[i] = (nxt[i] + 1) % fp[i];
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [11:0] d, input logic fs = 1'b0);
    rst = r; scaled_valid = v; scaled_data = d;
`ifdef SRAM_WRITER_FRAME_SYNC_EN
    frame_start = fs;
`endif
    @(posedge clk);
    #1;
`ifdef SRAM_WRITER_FRAME_SYNC_EN
    model(r, v, d, fs);
`else
    model(r, v, d, 1'b0);
`endif
    check("a_we", 32'(we_a), 32'(ew[0]));
    check("a_addr", 32'(addr_a), 32'(ea[0]));
    check("a_data", 32'(data_a), 32'(ed[0]));
    check("b_we", 32'(we_b), 32'(ew[1]));
    check("b_addr", 32'(addr_b), 32'(ea[1]));
    check("b_data", 32'(data_b), 32'(ed[1]));
    check("b_addr_in_range", 32'(addr_b < 17'd8), 32'd1);
`ifdef SRAM_WRITER_FRAME_SYNC_EN
    check("a_frame_done", 32'(fd_a), 32'(efd[0]));
    check("b_frame_done", 32'(fd_b), 32'(efd[1]));
`endif
  endtask

  initial begin
    fp[0] = 76800; fp[1] = 8;
    for (int i = 0; i < 2; i++) begin
      nxt[i] = 0; ea[i] = '0; ed[i] = '0; ew[i] = 1'b0; efd[i] = 1'b0;
    end

    step(1'b1, 1'b0, 12'h000);
    step(1'b1, 1'b1, 12'h5A5);
    check("reset_addr", 32'(addr_a), 32'd0);
    check("reset_we", 32'(we_a), 32'd0);

    // continuous write
    step(1'b0, 1'b1, 12'hAA1);
    check("first_addr_zero", 32'(addr_a), 32'd0);
    step(1'b0, 1'b1, 12'hAA2);
    step(1'b0, 1'b1, 12'hAA3);
    check("third_addr", 32'(addr_a), 32'd2);

    // gaps: 0xFFF must never be written
    step(1'b0, 1'b0, 12'hFFF);
    step(1'b0, 1'b0, 12'hFFF);
    check("gap_data_held", 32'(data_a), 32'hAA3);
    step(1'b0, 1'b1, 12'hBB1);
    step(1'b0, 1'b0, 12'hFFF);
    step(1'b0, 1'b1, 12'hBB2);
    check("gap_addr", 32'(addr_a), 32'd4);

    // wrap on the 8-pixel instance
    step(1'b1, 1'b0, 12'h000);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 12'(12'h300 + k));
    check("wrap_addr_b", 32'(addr_b), 32'd1);
    check("nowrap_addr_a", 32'(addr_a), 32'd9);

    // reset mid-stream while valid is high
    step(1'b1, 1'b0, 12'h000);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 12'(12'h400 + k));
    step(1'b1, 1'b1, 12'h777);
    check("midreset_we", 32'(we_a), 32'd0);
    step(1'b0, 1'b1, 12'h123);
    check("post_reset_addr", 32'(addr_a), 32'd0);
    check("post_reset_data", 32'(data_a), 32'h123);

    // idle hold after a write to address 4
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 12'(12'h500 + k));
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 12'($urandom));
    check("idle_addr_hold", 32'(addr_a), 32'd4);
    step(1'b0, 1'b1, 12'h600);
    check("after_idle_addr", 32'(addr_a), 32'd5);

`ifdef SRAM_WRITER_FRAME_SYNC_EN
    step(1'b1, 1'b0, 12'h000);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 12'(12'h700 + k));
    step(1'b0, 1'b1, 12'h7F0, 1'b1);
    check("frame_start_addr", 32'(addr_a), 32'd0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 12'(12'h710 + k));
    check("frame_done_last", 32'(fd_b), 32'd1);
`endif

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 12'($urandom),
           ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_writer.md
Name: sram_writer

Overview:
- Converts the downscaler's pixel stream (scaled_data/scaled_valid) into sequential write cycles on a single-port frame-buffer BRAM.
- Each accepted pixel is written to the next linear address; the address holds across gaps in the valid stream.
- Sits between the downscaler and the frame-buffer BRAM write port.
- Default frame is 320x240 = 76800 pixels, 12-bit RGB444.

Parameters:
- DATA_W, 12, pixel width in bits.
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= FRAME_PIXELS.
- FRAME_PIXELS, 76800, pixels per frame; the address wraps after FRAME_PIXELS-1.

Ports:
- clk  input  1  system clock (25 MHz pixel clock); all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- scaled_data  input  DATA_W  pixel from the downscaler.
- scaled_valid  input  1  scaled_data is valid this cycle.
- bram_addr  output  ADDR_W  BRAM write address (registered).
- bram_data  output  DATA_W  BRAM write data (registered).
- bram_we  output  1  BRAM write enable (registered).

Behaviour:
- Internal write pointer wr_ptr [ADDR_W-1:0]. No FSM and no backpressure; every valid pixel is accepted.
- Reset: synchronous, checked at the rising clk edge, overrides everything else.
  - bram_addr=0, bram_data=0, bram_we=0, wr_ptr=0.
- Cycle with scaled_valid=1 at a clk edge:
  - bram_we<=1, bram_data<=scaled_data, bram_addr<=wr_ptr.
  - wr_ptr<=wr_ptr+1, or 0 if wr_ptr==FRAME_PIXELS-1.
- Cycle with scaled_valid=0:
  - bram_we<=0.
  - bram_addr, bram_data and wr_ptr hold their values.
  - scaled_data is ignored and never reaches bram_data.
- Latency: exactly 1 clk from input sample to the write presented on the BRAM outputs.
- Back-to-back valids produce consecutive addresses with no bubbles.
- Address sequencing:
  - The first valid pixel after reset goes to address 0.
  - The Nth valid pixel (counting from 0) goes to address N mod FRAME_PIXELS.
  - Gaps of any length never skip or repeat an address.
- Wrap: the pixel after address FRAME_PIXELS-1 goes to address 0. bram_addr never reaches FRAME_PIXELS or above.
- Reset mid-stream:
  - The pending write is dropped (bram_we=0 the cycle after reset is sampled).
  - The next valid pixel goes to address 0.
- Arithmetic is unsigned. The wrap compare is done on wr_ptr, not on bram_addr.

Optional Feature:
- Macro SRAM_WRITER_FRAME_SYNC_EN.
- Defined: adds two ports.
  - Input frame_start (1 bit): when sampled high, forces wr_ptr to 0.
    - If scaled_valid is also high in that cycle, that pixel is written to address 0 and wr_ptr becomes 1.
    - frame_start has priority over wrap.
  - Output frame_done (1 bit, registered, reset 0): pulses high for one cycle together with the bram_we of the write to address FRAME_PIXELS-1.
- Not defined: neither port exists; behaviour is purely count-based wrap as above.

Test Plan:
- Reset then continuous write: valid=1 with data 0xAA1, 0xAA2, 0xAA3 on consecutive cycles -> writes (addr,data) (0,AA1), (1,AA2), (2,AA3), each one cycle after input, bram_we high 3 cycles.
- Gaps: valid=0 with data 0xFFF for 2 cycles, then 0xBB1, one idle cycle, then 0xBB2 -> bram_we low during gaps, no 0xFFF write, writes (3,BB1) and (4,BB2).
- Wrap: FRAME_PIXELS=8 override, 10 consecutive valid pixels -> addresses 0..7,0,1; bram_addr never reaches 8.
- Reset mid-stream: after 5 writes assert rst one cycle while valid=1 -> no write that cycle, outputs 0; next valid pixel 0x123 is written to addr 0.
- Idle hold: valid=0 for 100 cycles after a write to addr 4 -> bram_we=0 throughout, bram_addr stays 4, next valid goes to addr 5.
- With SRAM_WRITER_FRAME_SYNC_EN: frame_start with valid=1 after 3 writes -> that pixel goes to addr 0; with FRAME_PIXELS=8, frame_done pulses exactly with the write to addr 7.
